// File: rtl/alt_dfe_pkg.sv
// Shared constants and types for the DFE tap loader: DFE register map,
// control/status bit positions, error codes and the sequencer state encoding.
package alt_dfe_pkg;

    localparam logic [3:0] REG_CH   = 4'h0;
    localparam logic [3:0] REG_DATA = 4'h1;
    localparam logic [3:0] REG_CTRL = 4'h2;
    localparam logic [3:0] REG_STAT = 4'h3;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_RWN     = 1;
    localparam int CTRL_TAP_LSB = 2;
    localparam int STAT_BUSY    = 0;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_RANGE    = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SET_CH   = 4'd1,
        ST_SET_DATA = 4'd2,
        ST_CMD_WR   = 4'd3,
        ST_POLL     = 4'd4,
        ST_CMD_RD   = 4'd5,
        ST_GET      = 4'd6,
        ST_NEXT     = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERR      = 4'd9
    } state_e;

    // Low nibble of a CTRL command: go always set, rwn selects readback.
    function automatic logic [3:0] ctrl_word(input logic [1:0] tap, input logic rwn);
        ctrl_word = {tap, rwn, 1'b1};
    endfunction

endpackage

// File: rtl/alt_dfe_avmm_req.sv
// Single-request Avalon-MM holder. Accepts one request when idle, holds it
// unchanged through waitrequest, captures read data on the completing edge
// and raises a one-cycle ack the cycle after completion.
module alt_dfe_avmm_req #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_issue,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_idle,
    output logic                  req_ack,
    output logic [DATA_WIDTH-1:0] req_rdata,
    output logic [ADDR_WIDTH-1:0] avmm_address,
    output logic                  avmm_read,
    output logic                  avmm_write,
    output logic [DATA_WIDTH-1:0] avmm_writedata,
    input  logic [DATA_WIDTH-1:0] avmm_readdata,
    input  logic                  avmm_waitrequest
);

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  read_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  ack_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    // Ack cycle counts as busy so the issuer cannot stack a request onto it.
    assign req_idle       = !(read_r || write_r) && !ack_r;
    assign req_ack        = ack_r;
    assign req_rdata      = rdata_r;
    assign avmm_address   = addr_r;
    assign avmm_read      = read_r;
    assign avmm_write     = write_r;
    assign avmm_writedata = wdata_r;

    // Request launch, stall hold, completion with read capture and ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            read_r  <= 1'b0;
            write_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
            ack_r   <= 1'b0;
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            ack_r <= 1'b0;
            if (read_r || write_r) begin
                if (!avmm_waitrequest) begin
                    if (read_r) begin
                        rdata_r <= avmm_readdata;
                    end
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    ack_r   <= 1'b1;
                end
            end else if (req_issue && !ack_r) begin
                addr_r  <= req_addr;
                read_r  <= !req_write;
                write_r <= req_write;
                wdata_r <= req_wdata;
            end
        end
    end

endmodule

// File: rtl/alt_dfe_tap_loader.sv
// DFE tap loader: walks a channel range, writing channel/data/command
// registers per tap, polling status until idle, optionally reading back each
// tap, and reporting completion and the first failure location.
module alt_dfe_tap_loader
    import alt_dfe_pkg::*;
#(
    parameter int CH_WIDTH   = 3,
    parameter int NUM_TAPS   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int POLL_LIMIT = 1023
) (
    input  logic                           i_avmm_clk,
    input  logic                           i_resetn,
    input  logic                           i_start,
    input  logic                           i_verify,
    input  logic [CH_WIDTH-1:0]            i_ch_first,
    input  logic [CH_WIDTH-1:0]            i_ch_last,
    input  logic [NUM_TAPS*DATA_WIDTH-1:0] i_taps,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error,
    output logic [1:0]                     o_err_code,
    output logic [CH_WIDTH-1:0]            o_err_ch,
    output logic [1:0]                     o_err_tap,
    output logic [ADDR_WIDTH-1:0]          o_avmm_maddress,
    output logic                           o_avmm_mread,
    output logic                           o_avmm_mwrite,
    output logic [DATA_WIDTH-1:0]          o_avmm_mwritedata,
    input  logic [DATA_WIDTH-1:0]          i_avmm_mreaddata,
    input  logic                           i_avmm_mwaitrequest
);

    localparam int              PW        = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [1:0]      TAP_LAST  = 2'(NUM_TAPS - 1);

    state_e                                state_r, state_next_s;
    logic                                  verify_r, ret_rd_r;
    logic [CH_WIDTH-1:0]                   ch_r, ch_last_r;
    logic [1:0]                            tap_r;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   taps_r;
    logic [PW-1:0]                         poll_cnt_r;
    logic                                  busy_r, done_r, error_r;
    logic [1:0]                            err_code_r, err_tap_r;
    logic [CH_WIDTH-1:0]                   err_ch_r;

    logic                                  issue_s, issue_wr_s, req_idle_s, req_ack_s;
    logic [ADDR_WIDTH-1:0]                 issue_addr_s;
    logic [DATA_WIDTH-1:0]                 issue_wdata_s, req_rdata_s;
    logic                                  start_ok_s;

    assign start_ok_s = (state_r == ST_IDLE) && i_start;

    alt_dfe_avmm_req #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req (
        .clk              (i_avmm_clk),
        .rst_n            (i_resetn),
        .req_issue        (issue_s),
        .req_write        (issue_wr_s),
        .req_addr         (issue_addr_s),
        .req_wdata        (issue_wdata_s),
        .req_idle         (req_idle_s),
        .req_ack          (req_ack_s),
        .req_rdata        (req_rdata_s),
        .avmm_address     (o_avmm_maddress),
        .avmm_read        (o_avmm_mread),
        .avmm_write       (o_avmm_mwrite),
        .avmm_writedata   (o_avmm_mwritedata),
        .avmm_readdata    (i_avmm_mreaddata),
        .avmm_waitrequest (i_avmm_mwaitrequest)
    );

    // Sequencer state register.
    always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; register steps advance only on the holder's ack.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_next_s = (i_ch_first > i_ch_last) ? ST_ERR : ST_SET_CH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SET_CH:   state_next_s = req_ack_s ? ST_SET_DATA : ST_SET_CH;
            ST_SET_DATA: state_next_s = req_ack_s ? ST_CMD_WR : ST_SET_DATA;
            ST_CMD_WR:   state_next_s = req_ack_s ? ST_POLL : ST_CMD_WR;
            ST_CMD_RD:   state_next_s = req_ack_s ? ST_POLL : ST_CMD_RD;
            ST_POLL: begin
                if (!req_ack_s) begin
                    state_next_s = ST_POLL;
                end else if (!req_rdata_s[STAT_BUSY]) begin
                    if (ret_rd_r) begin
                        state_next_s = ST_GET;
                    end else if (verify_r) begin
                        state_next_s = ST_CMD_RD;
                    end else begin
                        state_next_s = ST_NEXT;
                    end
                end else if (poll_cnt_r == POLL_LAST) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_POLL;
                end
            end
            ST_GET: begin
                if (!req_ack_s) begin
                    state_next_s = ST_GET;
                end else if (req_rdata_s != taps_r[tap_r]) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (tap_r < TAP_LAST) begin
                    state_next_s = ST_SET_DATA;
                end else if (ch_r < ch_last_r) begin
                    state_next_s = ST_SET_CH;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request decode per state; issue only when the holder is free.
    always_comb begin
        issue_s       = 1'b0;
        issue_wr_s    = 1'b1;
        issue_addr_s  = {ADDR_WIDTH{1'b0}};
        issue_wdata_s = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_SET_CH: begin
                issue_s       = req_idle_s;
                issue_addr_s  = {{(ADDR_WIDTH-4){1'b0}}, REG_CH};
                issue_wdata_s = {{(DATA_WIDTH-CH_WIDTH){1'b0}}, ch_r};
            end
            ST_SET_DATA: begin
                issue_s       = req_idle_s;
                issue_addr_s  = {{(ADDR_WIDTH-4){1'b0}}, REG_DATA};
                issue_wdata_s = taps_r[tap_r];
            end
            ST_CMD_WR: begin
                issue_s       = req_idle_s;
                issue_addr_s  = {{(ADDR_WIDTH-4){1'b0}}, REG_CTRL};
                issue_wdata_s = {{(DATA_WIDTH-4){1'b0}}, ctrl_word(tap_r, 1'b0)};
            end
            ST_CMD_RD: begin
                issue_s       = req_idle_s;
                issue_addr_s  = {{(ADDR_WIDTH-4){1'b0}}, REG_CTRL};
                issue_wdata_s = {{(DATA_WIDTH-4){1'b0}}, ctrl_word(tap_r, 1'b1)};
            end
            ST_POLL: begin
                issue_s      = req_idle_s;
                issue_wr_s   = 1'b0;
                issue_addr_s = {{(ADDR_WIDTH-4){1'b0}}, REG_STAT};
            end
            ST_GET: begin
                issue_s      = req_idle_s;
                issue_wr_s   = 1'b0;
                issue_addr_s = {{(ADDR_WIDTH-4){1'b0}}, REG_DATA};
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Snapshot, channel/tap walk, poll counting, status and error capture.
    always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            verify_r   <= 1'b0;
            ret_rd_r   <= 1'b0;
            ch_r       <= {CH_WIDTH{1'b0}};
            ch_last_r  <= {CH_WIDTH{1'b0}};
            tap_r      <= 2'd0;
            taps_r     <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
            poll_cnt_r <= {PW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
            err_ch_r   <= {CH_WIDTH{1'b0}};
            err_tap_r  <= 2'd0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE) || (state_next_s == ST_ERR);

            if (start_ok_s) begin
                verify_r   <= i_verify;
                ch_r       <= i_ch_first;
                ch_last_r  <= i_ch_last;
                taps_r     <= i_taps;
                tap_r      <= 2'd0;
                error_r    <= 1'b0;
                err_code_r <= ERR_NONE;
                err_ch_r   <= {CH_WIDTH{1'b0}};
                err_tap_r  <= 2'd0;
            end else if (state_r == ST_NEXT) begin
                if (tap_r < TAP_LAST) begin
                    tap_r <= tap_r + 2'd1;
                end else if (ch_r < ch_last_r) begin
                    tap_r <= 2'd0;
                    ch_r  <= ch_r + {{(CH_WIDTH-1){1'b0}}, 1'b1};
                end
            end

            if (state_r == ST_CMD_WR) begin
                ret_rd_r   <= 1'b0;
                poll_cnt_r <= {PW{1'b0}};
            end else if (state_r == ST_CMD_RD) begin
                ret_rd_r   <= 1'b1;
                poll_cnt_r <= {PW{1'b0}};
            end else if ((state_r == ST_POLL) && req_ack_s && req_rdata_s[STAT_BUSY]) begin
                poll_cnt_r <= poll_cnt_r + {{(PW-1){1'b0}}, 1'b1};
            end

            // Placed after the start branch so a bad-range start still flags.
            if ((state_next_s == ST_ERR) && (state_r != ST_ERR)) begin
                error_r <= 1'b1;
                if (state_r == ST_IDLE) begin
                    err_code_r <= ERR_RANGE;
                    err_ch_r   <= i_ch_first;
                    err_tap_r  <= 2'd0;
                end else begin
                    err_code_r <= (state_r == ST_POLL) ? ERR_TIMEOUT : ERR_MISMATCH;
                    err_ch_r   <= ch_r;
                    err_tap_r  <= tap_r;
                end
            end
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_error    = error_r;
    assign o_err_code = err_code_r;
    assign o_err_ch   = err_ch_r;
    assign o_err_tap  = err_tap_r;

endmodule

// File: tb/tb_alt_dfe_tap_loader.sv
// Directed bench for alt_dfe_tap_loader: table of runs against a behavioural
// DFE slave, plus a hand sequence for reset mid-stall and start-while-busy.
module tb_alt_dfe_tap_loader;

    localparam int CHW = 3;
    localparam int NT  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int PL  = 7;

    logic              i_avmm_clk;
    logic              i_resetn;
    logic              i_start;
    logic              i_verify;
    logic [CHW-1:0]    i_ch_first;
    logic [CHW-1:0]    i_ch_last;
    logic [NT*DW-1:0]  i_taps;
    logic              o_busy, o_done, o_error;
    logic [1:0]        o_err_code;
    logic [CHW-1:0]    o_err_ch;
    logic [1:0]        o_err_tap;
    logic [AW-1:0]     o_avmm_maddress;
    logic              o_avmm_mread, o_avmm_mwrite;
    logic [DW-1:0]     o_avmm_mwritedata;
    logic [DW-1:0]     i_avmm_mreaddata;
    logic              i_avmm_mwaitrequest;

    alt_dfe_tap_loader #(
        .CH_WIDTH(CHW), .NUM_TAPS(NT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_LIMIT(PL)
    ) dut (
        .i_avmm_clk          (i_avmm_clk),
        .i_resetn            (i_resetn),
        .i_start             (i_start),
        .i_verify            (i_verify),
        .i_ch_first          (i_ch_first),
        .i_ch_last           (i_ch_last),
        .i_taps              (i_taps),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_error             (o_error),
        .o_err_code          (o_err_code),
        .o_err_ch            (o_err_ch),
        .o_err_tap           (o_err_tap),
        .o_avmm_maddress     (o_avmm_maddress),
        .o_avmm_mread        (o_avmm_mread),
        .o_avmm_mwrite       (o_avmm_mwrite),
        .o_avmm_mwritedata   (o_avmm_mwritedata),
        .i_avmm_mreaddata    (i_avmm_mreaddata),
        .i_avmm_mwaitrequest (i_avmm_mwaitrequest)
    );

    initial i_avmm_clk = 1'b0;
    always #5 i_avmm_clk = ~i_avmm_clk;

    typedef struct {
        bit          verify;
        int          ch_first;
        int          ch_last;
        logic [63:0] taps;
        int          stall;     // 0 none, 1 random 0..5
        int          corrupt;   // slave flips bit0 of ch3/tap2 readback
        int          stuck;     // status busy stuck high
        int          exp_err;
        int          exp_code;
        int          exp_ch;    // -1: location not checked
        int          exp_tap;
        int          exp_wr;
        int          exp_rd;
        int          exp_lat;   // 0: latency not checked
        int          inject;    // cycle to pulse a foreign start, 0 = none
    } vec_t;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } xfer_t;

    xfer_t log_q[$];
    xfer_t exp_q[$];
    int    total, bad;
    int    proto_bad, stab_bad;
    int    stall_mode, corrupt_en, stuck_en;
    logic [DW-1:0] mem [8][4];
    logic [DW-1:0] s_rd;
    int    s_ch;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Behavioural DFE slave, evaluated at negedge so DUT outputs are settled.
    initial begin : slave
        bit            in_req;
        int            stall_left;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd;
        logic          c_rd, c_wr;
        in_req = 1'b0;
        stall_left = 0;
        i_avmm_mwaitrequest = 1'b0;
        i_avmm_mreaddata = '0;
        s_rd = '0;
        s_ch = 0;
        forever begin
            @(negedge i_avmm_clk);
            if (o_avmm_mread && o_avmm_mwrite) proto_bad++;
            if (o_avmm_mread || o_avmm_mwrite) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    c_addr = o_avmm_maddress; c_wd = o_avmm_mwritedata;
                    c_rd = o_avmm_mread; c_wr = o_avmm_mwrite;
                    stall_left = (stall_mode == 1) ? int'($urandom_range(0, 5)) : 0;
                end else if (c_addr != o_avmm_maddress || c_rd != o_avmm_mread ||
                             c_wr != o_avmm_mwrite || (c_wr && c_wd != o_avmm_mwritedata)) begin
                    stab_bad++;
                end
                case (int'(o_avmm_maddress))
                    3: i_avmm_mreaddata = {15'd0, stuck_en[0]};
                    1: i_avmm_mreaddata = s_rd;
                    default: i_avmm_mreaddata = '0;
                endcase
                if (stall_mode == 2 || stall_left > 0) begin
                    i_avmm_mwaitrequest = 1'b1;
                    if (stall_left > 0) stall_left--;
                end else begin
                    i_avmm_mwaitrequest = 1'b0;
                    in_req = 1'b0;
                    log_q.push_back('{o_avmm_mwrite, int'(o_avmm_maddress),
                                      o_avmm_mwrite ? int'(o_avmm_mwritedata) : 0});
                    if (o_avmm_mwrite) begin
                        case (int'(o_avmm_maddress))
                            0: s_ch = int'(o_avmm_mwritedata[2:0]);
                            1: s_rd = o_avmm_mwritedata;
                            2: begin
                                if (!o_avmm_mwritedata[1])
                                    mem[s_ch][o_avmm_mwritedata[3:2]] = s_rd;
                                else
                                    s_rd = mem[s_ch][o_avmm_mwritedata[3:2]] ^
                                           ((corrupt_en != 0 && s_ch == 3 && o_avmm_mwritedata[3:2] == 2'd2) ? 16'd1 : 16'd0);
                            end
                            default: ;
                        endcase
                    end
                end
            end else begin
                in_req = 1'b0;
                i_avmm_mwaitrequest = 1'b0;
            end
        end
    end

    // Expected Avalon transfer list for one run, truncated at the planted failure.
    task automatic build_exp(input vec_t v);
        logic [63:0] tp;
        exp_q.delete();
        tp = v.taps;
        if (v.ch_first > v.ch_last) return;
        for (int ch = v.ch_first; ch <= v.ch_last; ch++) begin
            exp_q.push_back('{1'b1, 0, ch});
            for (int t = 0; t < NT; t++) begin
                exp_q.push_back('{1'b1, 1, int'(tp[t*16 +: 16])});
                exp_q.push_back('{1'b1, 2, (t << 2) | 1});
                if (v.stuck != 0) begin
                    for (int p = 0; p < PL; p++) exp_q.push_back('{1'b0, 3, 0});
                    return;
                end
                exp_q.push_back('{1'b0, 3, 0});
                if (v.verify) begin
                    exp_q.push_back('{1'b1, 2, (t << 2) | 3});
                    exp_q.push_back('{1'b0, 3, 0});
                    exp_q.push_back('{1'b0, 1, 0});
                    if (v.corrupt != 0 && ch == 3 && t == 2) return;
                end
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  lat, nwr, nrd, mism;
        bit  seen, busy0;
        stall_mode = v.stall; corrupt_en = v.corrupt; stuck_en = v.stuck;
        build_exp(v);
        log_q.delete();
        @(negedge i_avmm_clk);
        i_start = 1'b1; i_verify = v.verify;
        i_ch_first = CHW'(v.ch_first); i_ch_last = CHW'(v.ch_last); i_taps = v.taps;
        @(negedge i_avmm_clk);
        i_start = 1'b0;
        seen = 1'b0; lat = 0; busy0 = o_busy;
        for (int c = 0; c < 5000; c++) begin
            if (o_done) begin seen = 1'b1; lat = c + 1; break; end
            if (v.inject > 0 && c == v.inject) begin
                i_start = 1'b1; i_verify = 1'b1; i_ch_first = 3'd5; i_ch_last = 3'd2; i_taps = '1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_avmm_clk);
        end
        i_start = 1'b0;
        chk("done_seen", idx, int'(seen), 1);
        chk("busy_after_start", idx, int'(busy0), 1);
        chk("error", idx, int'(o_error), v.exp_err);
        chk("err_code", idx, int'(o_err_code), v.exp_code);
        if (v.exp_ch >= 0) begin
            chk("err_ch", idx, int'(o_err_ch), v.exp_ch);
            chk("err_tap", idx, int'(o_err_tap), v.exp_tap);
        end
        if (v.exp_lat > 0) chk("latency", idx, lat, v.exp_lat);
        nwr = 0; nrd = 0;
        foreach (log_q[k]) if (log_q[k].wr) nwr++; else nrd++;
        chk("n_writes", idx, nwr, v.exp_wr);
        chk("n_reads", idx, nrd, v.exp_rd);
        chk("seq_len", idx, log_q.size(), exp_q.size());
        mism = 0;
        foreach (exp_q[k]) begin
            if (k >= log_q.size()) mism++;
            else if (log_q[k].wr != exp_q[k].wr || log_q[k].addr != exp_q[k].addr ||
                     log_q[k].data != exp_q[k].data) mism++;
        end
        chk("seq_match", idx, mism, 0);
        @(negedge i_avmm_clk);
        chk("busy_cleared", idx, int'(o_busy), 0);
        chk("done_pulse", idx, int'(o_done), 0);
        chk("error_held", idx, int'(o_error), v.exp_err);
    endtask

    vec_t vecs[7];
    vec_t v6;

    initial begin
        total = 0; bad = 0; proto_bad = 0; stab_bad = 0;
        stall_mode = 0; corrupt_en = 0; stuck_en = 0;
        i_resetn = 1'b0; i_start = 1'b0; i_verify = 1'b0;
        i_ch_first = '0; i_ch_last = '0; i_taps = '0;
        foreach (mem[a, b]) mem[a][b] = '0;

        //        vfy f  l  taps                    stl cor stk err code ch tap wr  rd lat inj
        vecs[0] = '{0, 0, 1, 64'h1234_A5A5_0F0F_C3C3, 0, 0, 0, 0, 0, -1, 0, 18,  8, 0, 0};
        vecs[1] = '{0, 0, 1, 64'h1234_A5A5_0F0F_C3C3, 1, 0, 0, 0, 0, -1, 0, 18,  8, 0, 0};
        vecs[2] = '{1, 2, 4, 64'h1234_A5A5_0F0F_C3C3, 1, 1, 0, 1, 2,  3, 2, 23, 21, 0, 0};
        vecs[3] = '{0, 0, 0, 64'h1234_A5A5_0F0F_C3C3, 0, 0, 1, 1, 1,  0, 0,  3,  7, 0, 0};
        vecs[4] = '{0, 5, 2, 64'h1234_A5A5_0F0F_C3C3, 0, 0, 0, 1, 3, -1, 0,  0,  0, 1, 0};
        vecs[5] = '{1, 6, 7, 64'hBEEF_0001_8000_7FFE, 1, 0, 0, 0, 0, -1, 0, 26, 24, 0, 0};
        vecs[6] = '{0, 7, 7, 64'hBEEF_0001_8000_7FFE, 0, 0, 0, 0, 0, -1, 0,  9,  4, 0, 0};
        v6      = '{0, 6, 7, 64'h5555_AAAA_0102_F00D, 1, 0, 0, 0, 0,  0, 0, 18,  8, 0, 8};

        #12;
        chk("rst_busy", 0, int'(o_busy), 0);
        chk("rst_done", 0, int'(o_done), 0);
        chk("rst_error", 0, int'(o_error), 0);
        chk("rst_bus", 0, int'({o_avmm_mread, o_avmm_mwrite, o_avmm_maddress, o_avmm_mwritedata}), 0);
        @(negedge i_avmm_clk);
        i_resetn = 1'b1;
        repeat (2) @(negedge i_avmm_clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset asserted while a write is stalled on waitrequest.
        stall_mode = 2; corrupt_en = 0; stuck_en = 0;
        @(negedge i_avmm_clk);
        i_start = 1'b1; i_verify = 1'b0; i_ch_first = 3'd0; i_ch_last = 3'd1;
        @(negedge i_avmm_clk);
        i_start = 1'b0;
        for (int c = 0; c < 50 && !o_avmm_mwrite; c++) @(negedge i_avmm_clk);
        chk("stall_reached", 7, int'(o_avmm_mwrite && i_avmm_mwaitrequest), 1);
        repeat (3) @(negedge i_avmm_clk);
        #2 i_resetn = 1'b0;
        #1;
        chk("midrst_busy", 7, int'(o_busy), 0);
        chk("midrst_req", 7, int'({o_avmm_mread, o_avmm_mwrite}), 0);
        chk("midrst_bus", 7, int'({o_avmm_maddress, o_avmm_mwritedata}), 0);
        chk("midrst_status", 7, int'({o_done, o_error, o_err_code, o_err_ch, o_err_tap}), 0);
        @(negedge i_avmm_clk);
        stall_mode = 0;
        i_resetn = 1'b1;
        repeat (2) @(negedge i_avmm_clk);
        chk("postrst_idle", 7, int'(o_busy), 0);

        // Fresh run to ch 7 with a foreign bad-range start pulsed while busy.
        run_vec(8, v6);

        chk("proto_rd_wr", 9, proto_bad, 0);
        chk("req_stable", 9, stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
